// File: rtl/or_1bit_stim_gen_pkg.sv
// Shared types, constants and LFSR helpers for the OR-gate equivalence stimulus sequencer.
package or_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } stim_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          NUM_DIRECTED = 4;

    // Galois right-shift step: feedback from bit 0 folds into the tap positions.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero state would lock the LFSR forever.
    function automatic logic [15:0] seed_guard(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/or_1bit_stim_gen_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload; reset and load both go to the guarded seed.
module lfsr16
    import or_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_seed;

    assign w_seed = seed_guard(seed);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= w_seed;
        end else if (load) begin
            r_q <= w_seed;
        end else if (adv) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/or_1bit_stim_gen.sv
// Stimulus sequencer for the or_1bit equivalence pair: 4 directed vectors, then LFSR vectors,
// each followed by a settle window and a one-cycle compare strobe.
module or_1bit_stim_gen
    import or_stim_pkg::*;
#(
    parameter int          NUM_RANDOM    = 500,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
    localparam int         IDX_W         = $clog2(NUM_RANDOM + 5)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    output logic             a,
    output logic             b,
    output logic             vec_valid,
    output logic             cmp_strobe,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIRECTED - 1 + NUM_RANDOM);
    localparam logic [IDX_W-1:0] FIRST_RAND  = IDX_W'(NUM_DIRECTED);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    stim_state_t      r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_a, w_a_next;
    logic             r_b, w_b_next;
    logic             r_vec_valid, w_vec_valid_next;
    logic             r_cmp_strobe, w_cmp_strobe_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    logic             w_lfsr_load;
    logic             w_lfsr_adv;
    logic [15:0]      w_lfsr_q;
    logic [15:0]      w_look;
    logic [13:0]      w_look_unused;
    logic [1:0]       w_look_ab;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_rand_cur;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .seed  (LFSR_SEED),
        .adv   (w_lfsr_adv),
        .q     (w_lfsr_q)
    );

    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_rand_cur = (r_idx >= FIRST_RAND);

    // a/b are registered, so the next random vector is taken from the LFSR value it will
    // hold after this edge: stepped if the vector now finishing was itself random.
    assign w_look = w_rand_cur ? lfsr_step(w_lfsr_q) : w_lfsr_q;
    assign {w_look_unused, w_look_ab} = w_look;

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_cnt_next        = r_cnt;
        w_a_next          = r_a;
        w_b_next          = r_b;
        w_vec_valid_next  = r_vec_valid;
        w_cmp_strobe_next = r_cmp_strobe;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_lfsr_load       = 1'b0;
        w_lfsr_adv        = 1'b0;

        if (!stall) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_next     = ST_APPLY;
                        w_idx_next       = '0;
                        w_cnt_next       = '0;
                        w_a_next         = 1'b0;
                        w_b_next         = 1'b0;
                        w_vec_valid_next = 1'b1;
                        w_busy_next      = 1'b1;
                        w_done_next      = 1'b0;
                        w_lfsr_load      = 1'b1;
                    end
                end
                ST_APPLY: begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = '0;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_next      = ST_COMPARE;
                        w_cmp_strobe_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    w_cmp_strobe_next = 1'b0;
                    w_lfsr_adv        = w_rand_cur;
                    if (r_idx == LAST_IDX) begin
                        w_state_next     = ST_DONE;
                        w_vec_valid_next = 1'b0;
                        w_busy_next      = 1'b0;
                        w_done_next      = 1'b1;
                    end else begin
                        w_state_next = ST_APPLY;
                        w_idx_next   = w_idx_inc;
                        if (w_idx_inc < FIRST_RAND) begin
                            w_a_next = w_idx_inc[0];
                            w_b_next = w_idx_inc[1];
                        end else begin
                            w_a_next = w_look_ab[0];
                            w_b_next = w_look_ab[1];
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_vec_valid  <= 1'b0;
            r_cmp_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_cnt        <= w_cnt_next;
            r_a          <= w_a_next;
            r_b          <= w_b_next;
            r_vec_valid  <= w_vec_valid_next;
            r_cmp_strobe <= w_cmp_strobe_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign vec_valid  = r_vec_valid;
    assign cmp_strobe = r_cmp_strobe;
    assign vec_idx    = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_or_1bit_stim_gen.sv
// Directed bench for or_1bit_stim_gen: three configurations sharing clock, reset and start;
// only the NUM_RANDOM=2 instance gets its own stall input.
module tb_or_1bit_stim_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic stall_b;
    logic stall_0;

    logic       a_a, b_a, vv_a, cs_a, busy_a, done_a;
    logic [2:0] idx_a;
    logic       a_b, b_b, vv_b, cs_b, busy_b, done_b;
    logic [2:0] idx_b;
    logic       a_c, b_c, vv_c, cs_c, busy_c, done_c;
    logic [2:0] idx_c;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected (a + 2*b) per vector index, worked by hand from the directed pattern and
    // from the LFSR: ACE1 -> (1,0), E270 -> (0,0); zero seed -> 0001 -> (1,0).
    int tbl_a [4];
    int tbl_b [6];
    int tbl_c [5];

    always #5 clk = ~clk;

    or_1bit_stim_gen #(.NUM_RANDOM(0), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall_0),
        .a(a_a), .b(b_a), .vec_valid(vv_a), .cmp_strobe(cs_a),
        .vec_idx(idx_a), .busy(busy_a), .done(done_a)
    );

    or_1bit_stim_gen #(.NUM_RANDOM(2), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall_b),
        .a(a_b), .b(b_b), .vec_valid(vv_b), .cmp_strobe(cs_b),
        .vec_idx(idx_b), .busy(busy_b), .done(done_b)
    );

    or_1bit_stim_gen #(.NUM_RANDOM(1), .SETTLE_CYCLES(3), .LFSR_SEED(16'h0000)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall_0),
        .a(a_c), .b(b_c), .vec_valid(vv_c), .cmp_strobe(cs_c),
        .vec_idx(idx_c), .busy(busy_c), .done(done_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string dn, input logic ga, input logic gb, input logic gvv,
                             input logic gcs, input logic gbusy, input logic gdone,
                             input logic [2:0] gidx);
        chk({dn, "_rst_a"},    {7'd0, ga},    8'd0);
        chk({dn, "_rst_b"},    {7'd0, gb},    8'd0);
        chk({dn, "_rst_vv"},   {7'd0, gvv},   8'd0);
        chk({dn, "_rst_cs"},   {7'd0, gcs},   8'd0);
        chk({dn, "_rst_busy"}, {7'd0, gbusy}, 8'd0);
        chk({dn, "_rst_done"}, {7'd0, gdone}, 8'd0);
        chk({dn, "_rst_idx"},  {5'd0, gidx},  8'd0);
    endtask

    // Cycle c counts from the first cycle after the accepted start edge.
    task automatic chk_cyc(input string dn, input int c, input int per, input int nvec,
                           input int ab_exp, input logic ga, input logic gb, input logic gvv,
                           input logic gcs, input logic gbusy, input logic gdone,
                           input logic [2:0] gidx);
        int    v    = (c - 1) / per;
        int    ph   = (c - 1) % per;
        logic  live = (v < nvec);
        logic  strb = live && (ph == per - 1);
        string t    = $sformatf("%s_c%0d", dn, c);
        chk({t, "_a"},    {7'd0, ga},    {7'd0, ab_exp[0]});
        chk({t, "_b"},    {7'd0, gb},    {7'd0, ab_exp[1]});
        chk({t, "_vv"},   {7'd0, gvv},   {7'd0, live});
        chk({t, "_cs"},   {7'd0, gcs},   {7'd0, strb});
        chk({t, "_busy"}, {7'd0, gbusy}, {7'd0, live});
        chk({t, "_done"}, {7'd0, gdone}, {7'd0, ~live});
        if (live) chk({t, "_idx"}, {5'd0, gidx}, 8'(v));
    endtask

    // Runs dut_b to DONE, checking every strobe against the vector table in order.
    task automatic collect_b(input int n0, input string tag);
        int n   = n0;
        int cyc = 0;
        int ab;
        while (!done_b && cyc < 80) begin
            if (cs_b) begin
                ab = tbl_b[(n < 6) ? n : 5];
                chk($sformatf("%s_s%0d_idx", tag, n), {5'd0, idx_b}, 8'(n));
                chk($sformatf("%s_s%0d_a", tag, n), {7'd0, a_b}, {7'd0, ab[0]});
                chk($sformatf("%s_s%0d_b", tag, n), {7'd0, b_b}, {7'd0, ab[1]});
                n++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_strobes"}, 8'(n), 8'd6);
        chk({tag, "_done"}, {7'd0, done_b}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy_b}, 8'd0);
    endtask

    initial begin
        int va, vb, vc;
        tbl_a = '{0, 1, 2, 3};
        tbl_b = '{0, 1, 2, 3, 1, 0};
        tbl_c = '{0, 1, 2, 3, 1};
        rst_n   = 1'b0;
        start   = 1'b0;
        stall_b = 1'b0;
        stall_0 = 1'b0;

        repeat (3) tick();
        chk_reset("A", a_a, b_a, vv_a, cs_a, busy_a, done_a, idx_a);
        chk_reset("B", a_b, b_b, vv_b, cs_b, busy_b, done_b, idx_b);
        chk_reset("C", a_c, b_c, vv_c, cs_c, busy_c, done_c, idx_c);

        // First sweep on all three instances, cycle by cycle.
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            va = (c - 1) / 3;
            vb = (c - 1) / 3;
            vc = (c - 1) / 5;
            chk_cyc("A", c, 3, 4, tbl_a[(va < 4) ? va : 3],
                    a_a, b_a, vv_a, cs_a, busy_a, done_a, idx_a);
            chk_cyc("B", c, 3, 6, tbl_b[(vb < 6) ? vb : 5],
                    a_b, b_b, vv_b, cs_b, busy_b, done_b, idx_b);
            chk_cyc("C", c, 5, 5, tbl_c[(vc < 5) ? vc : 4],
                    a_c, b_c, vv_c, cs_c, busy_c, done_c, idx_c);
            tick();
        end

        // Restart from DONE; stall through vector 1 settle; start while busy is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("stl_pre_idx", {5'd0, idx_b}, 8'd1);
        chk("stl_pre_cs",  {7'd0, cs_b},  8'd0);
        stall_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("stl_k%0d_a", k),   {7'd0, a_b},   8'd1);
            chk($sformatf("stl_k%0d_b", k),   {7'd0, b_b},   8'd0);
            chk($sformatf("stl_k%0d_idx", k), {5'd0, idx_b}, 8'd1);
            chk($sformatf("stl_k%0d_cs", k),  {7'd0, cs_b},  8'd0);
        end
        stall_b = 1'b0;
        tick();
        chk("stl_strobe_cs",  {7'd0, cs_b},  8'd1);
        chk("stl_strobe_idx", {5'd0, idx_b}, 8'd1);
        chk("stl_strobe_a",   {7'd0, a_b},   8'd1);
        tick();
        chk("stl_v2_idx", {5'd0, idx_b}, 8'd2);
        chk("stl_v2_cs",  {7'd0, cs_b},  8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_idx",  {5'd0, idx_b},  8'd2);
        chk("busy_start_a",    {7'd0, a_b},    8'd0);
        chk("busy_start_b",    {7'd0, b_b},    8'd1);
        chk("busy_start_busy", {7'd0, busy_b}, 8'd1);
        collect_b(2, "stl");

        // Reset during vector 2 settle, then replay the full sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("rst_pre_idx", {5'd0, idx_b}, 8'd2);
        rst_n = 1'b0;
        tick();
        chk_reset("B_mid", a_b, b_b, vv_b, cs_b, busy_b, done_b, idx_b);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_idle_cs",   {7'd0, cs_b},   8'd0);
        chk("rst_idle_busy", {7'd0, busy_b}, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("replay_vv",   {7'd0, vv_b},  8'd1);
        chk("replay_idx0", {5'd0, idx_b}, 8'd0);
        collect_b(0, "replay");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/or_1bit_stim_gen.md
# or_1bit_stim_gen

Synthesizable stimulus sequencer sitting directly upstream of the `or_1bit` golden/post-route pair in the OR-gate equivalence bench. It drives the shared inputs `a`/`b` through an exhaustive directed sweep followed by a reproducible LFSR-driven random sweep. It also emits a one-cycle compare strobe once each vector has settled, so the downstream comparator samples both outputs at a deterministic point.

## Interface
- `NUM_RANDOM`, 500: number of random vectors after the 4 directed ones (0 allowed).
- `SETTLE_CYCLES`, 1: cycles between applying a vector and the compare strobe (≥1).
- `LFSR_SEED`, 16'hACE1: LFSR load value; 16'h0000 is replaced by 16'h0001.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE with `stall`=0.
- `stall`  in  1  freeze: state, counters, LFSR and all outputs hold.
- `a`  out  1  stimulus bit a.
- `b`  out  1  stimulus bit b.
- `vec_valid`  out  1  `a`/`b` carry a live vector.
- `cmp_strobe`  out  1  one-cycle pulse; downstream samples golden vs netlist now.
- `vec_idx`  out  $clog2(NUM_RANDOM+5)  index of current vector (0-3 directed, 4.. random).
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; held until next accepted `start` or reset.

## Operation
- States: IDLE, APPLY, SETTLE, COMPARE, DONE.
- IDLE/DONE: accepted `start` → APPLY; `done` clears, `busy` sets, `vec_idx`=0, LFSR reloads seed.
- APPLY (1 cycle): `a`/`b` update, `vec_valid`=1 → SETTLE.
- SETTLE: stays `SETTLE_CYCLES` cycles → COMPARE.
- COMPARE (1 cycle): `cmp_strobe`=1. If `vec_idx` = 3+NUM_RANDOM → DONE, else `vec_idx`++ → APPLY.
- Directed vectors, idx 0-3: a=idx[0], b=idx[1], i.e. (a,b) = (0,0),(1,0),(0,1),(1,1).
- Random vectors: 16-bit Galois LFSR, right shift, taps mask 16'hB400.
  - a=lfsr[0], b=lfsr[1].
  - Random vector k uses the value after k advances from seed.
  - LFSR advances in COMPARE of each random vector only.
- DONE: `vec_valid`=0, `busy`=0, `done`=1. `a`/`b` keep the last vector.
- `start` while busy is ignored.
- `stall` has priority over `start` and over every transition.

## Timing
- Reset (`rst_n`=0 at an edge, any state): state=IDLE, `a`=`b`=0, `vec_valid`=`cmp_strobe`=`busy`=`done`=0, `vec_idx`=0, LFSR=seed.
- Reset mid-sweep aborts with no further strobe.
- Accepted `start` at edge 0: APPLY in cycle 1, first strobe in cycle 2+SETTLE_CYCLES.
- Per-vector period: SETTLE_CYCLES+2 cycles.
- `done` rises the cycle after the last COMPARE.
- `a`/`b` are stable from APPLY through COMPARE of each vector.
- `cmp_strobe` is never asserted for more than one unstalled cycle.
- If `stall` is high during COMPARE, the strobe extends by the number of stalled cycles.
- `vec_idx` counter width rule: sized so that 3+NUM_RANDOM fits without wrap.

## Structure
- Package `or_stim_pkg`:
  - state enum `stim_state_t`;
  - `LFSR_TAPS`=16'hB400;
  - `DEFAULT_SEED`=16'hACE1;
  - `NUM_DIRECTED`=4.
- One sub-module, `lfsr16`: ports `clk`, `rst_n`, `load`, `seed`, `adv`, `q`; zero-seed guard inside.

## Test plan
- Reset, start at edge 0 (NUM_RANDOM=0, SETTLE=1) → (a,b) = 00,10,01,11; strobes in cycles 3,6,9,12; `done`=1 from cycle 13; `vec_idx` 0..3.
- NUM_RANDOM=2, default seed → random vectors (a,b) = (1,0) from 16'hACE1, then (0,0) from 16'hE270; `done` after 6 strobes.
- `stall` high for 4 cycles during SETTLE of vector 1 → vector 1 strobe delayed by exactly 4 cycles; `a`/`b`/`vec_idx` unchanged throughout.
- `rst_n` low mid-vector 2 → next cycle all outputs at reset values; a new `start` replays from vector 0 with an identical sequence.
- `start` pulsed while busy → ignored; a second `start` in DONE → identical sweep, LFSR reseeded.
- SETTLE_CYCLES=3 → strobe spacing 5 cycles; first strobe in cycle 5.
